// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits a commanded number of A/B quadrature edges
// at a programmable step period and keeps a signed count of the emitted edges.
module quad_encoder_gen #(
  parameter int PER_W  = 16,
  parameter int STEP_W = 16,
  parameter int POS_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_dir,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic [PER_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic                    A,
  output logic                    B,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_n;
  logic [PER_W-1:0]          timer, timer_n;
  logic [PER_W-1:0]          per_last, per_last_n;
  logic [STEP_W-1:0]         remaining, remaining_n;
  logic                      ccw, ccw_n;
  logic                      a_n, b_n, done_n;
  logic signed [POS_W-1:0]   position_n;
  logic                      cmd_null;

  assign cmd_null  = (cmd_steps == '0) || (cmd_dir == 2'b00) || (cmd_dir == 2'b11);
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    state_n     = state;
    timer_n     = timer;
    per_last_n  = per_last;
    remaining_n = remaining;
    ccw_n       = ccw;
    a_n         = A;
    b_n         = B;
    position_n  = position;
    done_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_null) begin
            done_n = 1'b1;
          end else begin
            state_n     = RUN;
            timer_n     = '0;
            remaining_n = cmd_steps;
            ccw_n       = cmd_dir[1];
            // Timer compares against P-1; a zero period behaves as one.
            per_last_n  = (cmd_period == '0) ? '0 : cmd_period - PER_W'(1);
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (timer == per_last) begin
          timer_n     = '0;
          remaining_n = remaining - STEP_W'(1);
          // AB walks 00->10->11->01 for CW; CCW is the inverse map.
          if (ccw) begin
            a_n        = B;
            b_n        = ~A;
            position_n = position - POS_W'(1);
          end else begin
            a_n        = ~B;
            b_n        = A;
            position_n = position + POS_W'(1);
          end
          if (remaining == STEP_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          timer_n = timer + PER_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      per_last  <= '0;
      remaining <= '0;
      ccw       <= 1'b0;
      A         <= 1'b0;
      B         <= 1'b0;
      position  <= '0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_n;
      timer     <= timer_n;
      per_last  <= per_last_n;
      remaining <= remaining_n;
      ccw       <= ccw_n;
      A         <= a_n;
      B         <= b_n;
      position  <= position_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: a 16-bit and a 4-bit position instance share one
// stimulus stream and are compared every cycle against a step-count model.
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_dir = 2'b00;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;

  logic        a16, b16, ready16, busy16, done16;
  logic        a4, b4, ready4, busy4, done4;
  logic [15:0] pos16;
  logic [3:0]  pos4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  quad_encoder_gen #(.PER_W(16), .STEP_W(16), .POS_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready16),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .A(a16), .B(b16), .position(pos16), .busy(busy16), .done(done16)
  );

  quad_encoder_gen #(.PER_W(16), .STEP_W(16), .POS_W(4)) dut_small (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready4),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .A(a4), .B(b4), .position(pos4), .busy(busy4), .done(done4)
  );

  // Reference model: position and phase index are committed per move; while a
  // move runs, the steps emitted so far are elapsed_edges / P.
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  bit m_busy, m_done;
  int m_pos, m_idx, m_elapsed, m_n, m_p, m_sign;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_steps();
    return m_busy ? (m_elapsed / m_p) : 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_pos = 0; m_idx = 0;
    m_elapsed = 0; m_n = 0; m_p = 1; m_sign = 1;
  endtask

  task automatic commit(input int k);
    m_pos += m_sign * k;
    m_idx += m_sign * k;
  endtask

  task automatic model_edge();
    if (m_busy) begin
      m_elapsed++;
      if (abort) begin
        commit((m_elapsed - 1) / m_p);
        m_busy = 0;
        m_done = 1;
      end else if (m_elapsed / m_p == m_n) begin
        commit(m_n);
        m_busy = 0;
        m_done = 1;
      end else begin
        m_done = 0;
      end
    end else begin
      m_done = 0;
      if (cmd_valid) begin
        if (cmd_steps == 0 || cmd_dir == 2'b00 || cmd_dir == 2'b11) begin
          m_done = 1;
        end else begin
          m_busy    = 1;
          m_elapsed = 0;
          m_n       = int'(cmd_steps);
          m_p       = (cmd_period == 0) ? 1 : int'(cmd_period);
          m_sign    = (cmd_dir == 2'b01) ? 1 : -1;
        end
      end
    end
  endtask

  task automatic compare_all();
    int pe;
    int ix;
    logic [1:0] ab;
    pe = m_pos + m_sign * cur_steps();
    ix = m_idx + m_sign * cur_steps();
    ab = ab_tab[ix & 3];
    check("A", a16, ab[1]);
    check("B", b16, ab[0]);
    check("pos", pos16, pe[15:0]);
    check("A_small", a4, ab[1]);
    check("B_small", b4, ab[0]);
    check("pos_small", pos4, pe[3:0]);
    check("done", done16, m_done);
    check("ready", ready16, !m_busy);
    check("busy", busy16, m_busy);
  endtask

  // One clock: model sees the inputs at the rising edge, outputs checked at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [1:0] d, input int s, input int p);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = s[15:0];
    cmd_period = p[15:0];
    cycle();
    cmd_valid  = 1'b0;
    cmd_dir    = 2'($urandom);
    cmd_steps  = 16'($urandom);
    cmd_period = 16'($urandom);
  endtask

  task automatic run_idle(input int budget);
    int g = 0;
    while (m_busy && g < budget) begin
      cycle();
      g++;
    end
    check("reach_idle", ready16, 1'b1);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_A", a16, 1'b0);
    check("rst_B", b16, 1'b0);
    check("rst_pos", pos16, 16'h0000);
    check("rst_ready", ready16, 1'b1);
    check("rst_busy", busy16, 1'b0);
    check("rst_done", done16, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // CW move: AB 10,11,01,00 at edges 3,6,9,12, then done.
    send(2'b01, 4, 3);
    run_idle(50);
    check("cw_pos", pos16, 16'd4);
    check("cw_done", done16, 1'b1);

    // Reset in the middle of a move.
    send(2'b01, 10, 4);
    repeat (7) cycle();
    do_reset();

    // CCW from AB=11.
    send(2'b01, 2, 1);
    run_idle(20);
    check("pre_ccw_ab", {a16, b16}, 2'b11);
    send(2'b10, 3, 1);
    run_idle(20);
    check("ccw_pos", pos16, 16'hFFFF);
    check("ccw_ab", {a16, b16}, 2'b01);

    // Null commands: done pulse only.
    send(2'b00, 5, 2);
    check("null_dir_done", done16, 1'b1);
    send(2'b01, 0, 2);
    check("null_steps_done", done16, 1'b1);
    check("null_pos", pos16, 16'hFFFF);
    cycle();

    // Period 0 behaves as period 1.
    send(2'b01, 2, 0);
    cycle();
    check("p0_first", pos16, 16'h0000);
    cycle();
    check("p0_second", pos16, 16'h0001);

    // Abort at edge 25 of a 100-step, period-10 move.
    do_reset();
    send(2'b01, 100, 10);
    repeat (24) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_pos", pos16, 16'd2);
    check("abort_done", done16, 1'b1);
    send(2'b10, 1, 1);
    check("after_abort_accept", busy16, 1'b1);
    run_idle(10);

    // Wrap of the 4-bit position: 7 -> -8 on the eighth CW step.
    do_reset();
    send(2'b01, 9, 1);
    repeat (7) cycle();
    check("wrap_seven", pos4, 4'h7);
    cycle();
    check("wrap_minus8", pos4, 4'h8);
    run_idle(10);
    check("wrap_end16", pos16, 16'd9);

    // Randomized commands with junk inputs while running and random aborts.
    repeat (60) begin
      int r, s, p, g;
      logic [1:0] d;
      r = $urandom_range(0, 9);
      d = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      s = $urandom_range(0, 12);
      p = $urandom_range(0, 4);
      send(d, s, p);
      g = 0;
      while (m_busy && g < 500) begin
        abort      = ($urandom_range(0, 39) == 0);
        cmd_valid  = 1'($urandom);
        cmd_dir    = 2'($urandom);
        cmd_steps  = 16'($urandom);
        cmd_period = 16'($urandom);
        cycle();
        g++;
      end
      abort     = 1'b0;
      cmd_valid = 1'b0;
      check("rand_idle", ready16, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        abort = 1'($urandom);
        cycle();
      end
      abort = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
